hgcal_input_quantizer: RTL and testbench

//  Front end of the HGCAL autoencoder LUT network, directly upstream of the layer-0 neuron tables.

---
 rtl/hgcal_input_quantizer.sv | 141 ++++++++++++++
 tb/tb_hgcal_input_quantizer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hgcal_input_quantizer.sv
// Collects one event of cell-charge words, quantizes each cell with saturation and
// presents the packed event once under valid/ready; malformed events are dropped with an err pulse.
module hgcal_input_quantizer #(
    parameter int NUM_CELLS = 48,
    parameter int IN_WIDTH  = 16,
    parameter int Q_BITS    = 2,
    parameter int SHIFT     = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [IN_WIDTH-1:0]           s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [NUM_CELLS*Q_BITS-1:0]   m_data,
    output logic                          err
);

    localparam int CNT_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam logic [CNT_W-1:0]    LAST_IDX  = CNT_W'(NUM_CELLS - 1);
    localparam logic [Q_BITS-1:0]   Q_MAX     = '1;
    localparam logic [IN_WIDTH-1:0] Q_MAX_EXT = {{(IN_WIDTH-Q_BITS){1'b0}}, Q_MAX};

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                s_ready_q, s_ready_d;
    logic                m_valid_q, m_valid_d;
    logic                err_q, err_d;
    logic                wr_en;
    logic [Q_BITS-1:0]   cell_q [NUM_CELLS];
    logic [NUM_CELLS-1:0] wr_sel;

    logic                beat;
    logic [IN_WIDTH-1:0] shifted;
    logic [Q_BITS-1:0]   q_val;

    assign beat    = s_valid && s_ready_q;
    assign shifted = s_data >> SHIFT;
    assign q_val   = (shifted > Q_MAX_EXT) ? Q_MAX : shifted[Q_BITS-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        err_d     = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (beat) begin
                    wr_en = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
                        if (s_last) begin
                            state_d   = ST_HOLD;
                            m_valid_d = 1'b1;
                        end else begin
                            // Too many cells: discard the rest of this event up to its s_last.
                            state_d = ST_DRAIN;
                            err_d   = 1'b1;
                        end
                    end else if (s_last) begin
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (beat && s_last) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    state_d   = ST_FILL;
                    m_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_FILL;
                cnt_d     = '0;
                m_valid_d = 1'b0;
            end
        endcase
        s_ready_d = (state_d != ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FILL;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            assign wr_sel[gi] = wr_en && (cnt_q == CNT_W'(gi));
            assign m_data[gi*Q_BITS +: Q_BITS] = cell_q[gi];
        end
    endgenerate

    // Packing register is written one cell per beat and never cleared on handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                cell_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                if (wr_sel[i]) begin
                    cell_q[i] <= q_val;
                end
            end
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign err     = err_q;

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Directed + randomized bench for hgcal_input_quantizer; expected packed events come
// from a plain arithmetic model of the quantizer rule (divide by 1024, clamp to 3).
module tb_hgcal_input_quantizer;

    localparam int NC = 48;
    localparam int DW = NC * 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [15:0]   s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          err;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int hs_cnt   = 0;
    int ev [64];
    logic [DW-1:0] exp_pack;
    logic [DW-1:0] prev_data;
    logic          prev_valid = 1'b0;

    hgcal_input_quantizer #(
        .NUM_CELLS(NC), .IN_WIDTH(16), .Q_BITS(2), .SHIFT(10)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference quantizer: integer divide by the 2^10 scale, clamp to the 2-bit max.
    function automatic logic [DW-1:0] model_pack();
        logic [DW-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < NC; i++) begin
            v = ev[i] / 1024;
            if (v > 3) v = 3;
            r[i*2 +: 2] = 2'(v);
        end
        return r;
    endfunction

    function automatic int rand_word();
        case ($urandom_range(0, 4))
            0: return int'($urandom_range(0, 1023));
            1: return int'($urandom_range(1024, 2047));
            2: return int'($urandom_range(2048, 3071));
            3: return int'($urandom_range(3072, 4095));
            default: return int'($urandom_range(0, 65535));
        endcase
    endfunction

    task automatic randomize_event();
        for (int i = 0; i < 64; i++) ev[i] = rand_word();
    endtask

    always @(negedge clk) begin
        if (err) err_cnt++;
        if (m_valid && m_ready) hs_cnt++;
        if (m_valid && prev_valid) chk("hold_stable", m_data, prev_data);
        if (err && m_valid) chk("err_in_hold", {95'd0, err}, '0);
        prev_valid <= m_valid;
        prev_data  <= m_data;
    end

    task automatic wait_accept();
        int  guard;
        logic ok;
        guard = 0;
        do begin
            ok = s_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 200);
        if (!ok) begin
            checks++;
            failures++;
            $error("FAIL accept_timeout observed=s_ready_low expected=beat_accepted");
        end
    endtask

    // err_beat: index after which an err pulse is expected on the next cycle (-1: none).
    task automatic send_event(input int n, input int last_at, input int err_beat);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(ev[i]);
            s_last  = (i == last_at);
            wait_accept();
            if (i == err_beat) begin
                @(negedge clk);
                chk("long_err_pulse", {95'd0, err}, 96'd1);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    // After a good event with m_ready=1: one-cycle latency, data, then handoff.
    task automatic check_good_event(input string tag);
        @(negedge clk);
        chk({tag, "_mvalid"}, {95'd0, m_valid}, 96'd1);
        chk({tag, "_data"}, m_data, exp_pack);
        @(posedge clk);
        #1;
        chk({tag, "_sready_after"}, {95'd0, s_ready}, 96'd1);
        chk({tag, "_mvalid_after"}, {95'd0, m_valid}, 96'd0);
    endtask

    initial begin
        int e0, h0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sready", {95'd0, s_ready}, 96'd0);
        chk("rst_mvalid", {95'd0, m_valid}, 96'd0);
        chk("rst_mdata", m_data, '0);
        chk("rst_err", {95'd0, err}, 96'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("sready_before_rise", {95'd0, s_ready}, 96'd0);
        @(posedge clk); #1;
        chk("sready_rise", {95'd0, s_ready}, 96'd1);
        $display("step reset done");

        // Full event with ramped charges.
        m_ready = 1'b1;
        for (int i = 0; i < 64; i++) ev[i] = (i << 10) & 16'hFFFF;
        exp_pack = model_pack();
        e0 = err_cnt;
        send_event(NC, NC - 1, -1);
        check_good_event("ramp");
        chk("ramp_no_err", 96'(err_cnt - e0), 96'd0);
        $display("step ramp event done");

        // Shift and saturation corners in cells 0..3.
        randomize_event();
        ev[0] = 16'h03FF; ev[1] = 16'h0400; ev[2] = 16'h0BFF; ev[3] = 16'hFFFF;
        exp_pack = model_pack();
        send_event(NC, NC - 1, -1);
        check_good_event("sat");
        $display("step saturation event done");

        // Randomized good events back-to-back.
        for (int k = 0; k < 3; k++) begin
            randomize_event();
            exp_pack = model_pack();
            send_event(NC, NC - 1, -1);
            check_good_event("rand");
            $display("step random event %0d done", k);
        end

        // Backpressure: downstream stalls for 20 cycles.
        m_ready = 1'b0;
        randomize_event();
        exp_pack = model_pack();
        send_event(NC, NC - 1, -1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp_sready", {95'd0, s_ready}, 96'd0);
            chk("bp_mvalid", {95'd0, m_valid}, 96'd1);
            chk("bp_data", m_data, exp_pack);
        end
        @(posedge clk); #1;
        h0 = hs_cnt;
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_sready_after", {95'd0, s_ready}, 96'd1);
        chk("bp_mvalid_after", {95'd0, m_valid}, 96'd0);
        repeat (3) @(negedge clk);
        chk("bp_one_handshake", 96'(hs_cnt - h0), 96'd1);
        $display("step backpressure done");

        // Short event: s_last on beat 10.
        randomize_event();
        e0 = err_cnt; h0 = hs_cnt;
        send_event(11, 10, -1);
        @(negedge clk);
        chk("short_err", {95'd0, err}, 96'd1);
        chk("short_no_mvalid", {95'd0, m_valid}, 96'd0);
        repeat (3) @(negedge clk);
        chk("short_err_once", 96'(err_cnt - e0), 96'd1);
        chk("short_no_hs", 96'(hs_cnt - h0), 96'd0);
        randomize_event();
        exp_pack = model_pack();
        send_event(NC, NC - 1, -1);
        check_good_event("after_short");
        $display("step short event done");

        // Long event: 52 beats, s_last on beat 51.
        randomize_event();
        e0 = err_cnt; h0 = hs_cnt;
        send_event(52, 51, NC - 1);
        repeat (3) @(negedge clk);
        chk("long_err_once", 96'(err_cnt - e0), 96'd1);
        chk("long_no_hs", 96'(hs_cnt - h0), 96'd0);
        randomize_event();
        exp_pack = model_pack();
        send_event(NC, NC - 1, -1);
        check_good_event("after_long");
        $display("step long event done");

        // Reset after beat 20 of an event.
        randomize_event();
        send_event(21, -1, -1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_sready", {95'd0, s_ready}, 96'd0);
        chk("mid_rst_mvalid", {95'd0, m_valid}, 96'd0);
        chk("mid_rst_mdata", m_data, '0);
        chk("mid_rst_err", {95'd0, err}, 96'd0);
        @(posedge clk); #1;
        chk("mid_rst_sready_rise", {95'd0, s_ready}, 96'd1);
        randomize_event();
        exp_pack = model_pack();
        send_event(NC, NC - 1, -1);
        check_good_event("after_rst");
        $display("step mid-event reset done");

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
